burst_sequencer: RTL and testbench
==================================

# burst_sequencer

Upstream driver for the pulse-generator-with-counter stage. Buffers a queue of 4-bit burst lengths, launches each one by presenting its length on `pg_limit` with a one-cycle `pg_start` pulse, waits for the generator's `pg_stop`, then inserts a programmable idle gap before the next burst. This turns a list of pulse widths into a back-to-back pulse train without CPU or testbench babysitting.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `GAP_W`, 4: width of the `gap` input.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_en`  in  1  push `wr_data` into the FIFO.
- `wr_data`  in  4  burst length; 1..15 are valid.
- `enable`  in  1  permit new bursts to launch.
- `gap`  in  GAP_W  idle cycles between bursts; sampled when GAP is entered.
- `pg_stop`  in  1  terminal indication from the pulse generator.
- `pg_start`  out  1  single-cycle launch pulse.
- `pg_limit`  out  4  length of the current burst.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `busy`  out  1  state is not IDLE.
- `wr_err`  out  1  one-cycle pulse when a write is rejected.
- `done_count`  out  8  bursts completed; wraps.

## Operation
- The FIFO is synchronous, with registered `full`/`empty` and pointer width log2(DEPTH)+1.
- A write is rejected, with `wr_err` pulsing the next cycle and FIFO unchanged, if:
  - `wr_data == 0`, or
  - the FIFO is full and no pop occurs that cycle.
- If a write and a pop happen in the same cycle while the FIFO is full, both succeed.
- If a write and a pop happen in the same cycle while the FIFO is empty, no pop occurs. The written entry is poppable from the next cycle.
- FSM states: IDLE, LAUNCH, WAIT, GAP.
  - **IDLE:** if `enable && !empty`, pop the head into the `pg_limit` register and go to LAUNCH. Otherwise stay.
  - **LAUNCH:** `pg_start=1` for exactly this cycle. `pg_stop` is ignored here (stale). Go to WAIT.
  - **WAIT:** stay until `pg_stop==1` is sampled. Then increment `done_count` (255 wraps to 0). If `gap==0`, go to IDLE; else load gap counter with `gap` and go to GAP.
  - **GAP:** decrement the counter each cycle. Leave for IDLE on the cycle the counter reads 1.
- `pg_limit` is registered and holds its value from LAUNCH until the next pop. It never changes during LAUNCH or WAIT.
- `enable` is checked only in IDLE. Deasserting it mid-burst lets WAIT and GAP complete, then the FSM parks in IDLE.
- `busy` is 1 in LAUNCH, WAIT and GAP.
- Reset: FIFO is emptied and state goes to IDLE. Output values during reset and the cycle after:
  - `pg_start=0`, `pg_limit=0`, `full=0`, `empty=1`, `busy=0`, `wr_err=0`, `done_count=0`.
  - Reset during any state aborts the burst; no `pg_start` is issued in that cycle.

## Timing
- Write-to-status:
  - A write at edge N clears `empty` at N+1.
  - If IDLE and enabled, `pg_start` is high in cycle N+2.
  - `pg_limit` is valid in the same cycle as `pg_start`.
- Launch pacing:
  - The first WAIT cycle is the cycle after `pg_start`.
  - `pg_stop` sampled high at edge M gives: GAP for cycles M+1..M+gap, IDLE at M+gap+1, next `pg_start` at M+gap+2.
  - With `gap==0`: IDLE at M+1, `pg_start` at M+2.
- At most one `pg_start` per burst. `pg_start` is never asserted on consecutive cycles.
- `wr_err` is high the cycle after the rejected write.
- `done_count` updates the cycle after `pg_stop` is sampled in WAIT.

## Test plan
1. **Single burst.** After reset, write 5 with `enable=1` and `gap=2`; model `pg_stop` 5 cycles after `pg_start`.
   -> `pg_start` is one cycle, two cycles after the write, with `pg_limit=5`; `done_count=1`; `busy` drops 3 cycles after `pg_stop`.
2. **Queued train.** Write 3, 7, 1 back-to-back with `gap=0`.
   -> Three `pg_start` pulses with `pg_limit` 3, 7, 1 in order; each starts 2 cycles after the prior `pg_stop`; `empty=1` after the third pop; `done_count=3`.
3. **Full and rejects.** With `DEPTH=8` and `enable=0`, write 8 values.
   -> `full=1`.
   Then a 9th write and a write of 0 -> each pulses `wr_err`; the FIFO contents are unchanged (verified by draining).
4. **Enable gating.** Deassert `enable` during WAIT of burst 1 with 2 entries queued.
   -> Burst 1 completes; the FSM stays in IDLE with no `pg_start` until `enable` rises, then launches the next entry 1 cycle later.
5. **Stale stop / reset abort.**
   - Hold `pg_stop=1` during LAUNCH -> it is ignored; WAIT still waits for `pg_stop` sampled in WAIT.
   - Assert `rst` in WAIT -> all outputs take reset values next cycle and the FIFO is empty.
6. **Wrap.** Run 256 bursts of length 1.
   -> `done_count` reads 0 after the 256th.

Source files
------------

// File: rtl/burst_sequencer.sv
// Burst sequencer: FIFO of 4-bit burst lengths feeding a pulse generator,
// one launch per entry with a programmable idle gap after each completed burst.
module burst_sequencer #(
    parameter int DEPTH = 8,
    parameter int GAP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [3:0]       wr_data,
    input  logic             enable,
    input  logic [GAP_W-1:0] gap,
    input  logic             pg_stop,
    output logic             pg_start,
    output logic [3:0]       pg_limit,
    output logic             full,
    output logic             empty,
    output logic             busy,
    output logic             wr_err,
    output logic [7:0]       done_count
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, GAP} state_t;

    state_t           state, state_nxt;
    logic [3:0]       mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, level_nxt;
    logic             full_q, empty_q, wr_err_q;
    logic             push, pop, launch_st, busy_st;
    logic [GAP_W-1:0] gap_cnt;
    logic [3:0]       limit_q;
    logic [7:0]       done_q;

    // A full FIFO still accepts a write when the same cycle pops an entry.
    always_comb begin
        push       = wr_en && (wr_data != 4'd0) && (!full_q || pop);
        wr_ptr_nxt = wr_ptr + (AW+1)'(push);
        rd_ptr_nxt = rd_ptr + (AW+1)'(pop);
        level_nxt  = wr_ptr_nxt - rd_ptr_nxt;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            wr_err_q <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            full_q   <= (level_nxt == (AW+1)'(DEPTH));
            empty_q  <= (level_nxt == '0);
            wr_err_q <= wr_en && !push;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT;
            WAIT:    if (pg_stop) state_nxt = (gap == '0) ? IDLE : GAP;
            GAP:     if (gap_cnt == GAP_W'(1)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pop       = (state == IDLE) && enable && !empty_q;
        launch_st = (state == LAUNCH);
        busy_st   = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
            limit_q <= '0;
            done_q  <= '0;
        end else begin
            if (pop)
                limit_q <= mem[rd_ptr[AW-1:0]];
            if (state == WAIT && pg_stop) begin
                done_q  <= done_q + 8'd1;
                gap_cnt <= gap;
            end else if (state == GAP) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Outputs are forced to their reset values while rst is held, so an
    // in-flight LAUNCH never emits pg_start in the reset cycle.
    always_comb begin
        pg_start   = launch_st && !rst;
        busy       = busy_st && !rst;
        pg_limit   = rst ? 4'd0 : limit_q;
        full       = full_q && !rst;
        empty      = empty_q || rst;
        wr_err     = wr_err_q && !rst;
        done_count = rst ? 8'd0 : done_q;
    end

endmodule

// File: tb/tb_burst_sequencer.sv
// Randomized bench for burst_sequencer: a queue-based reference model predicts
// every output after each clock edge.
module tb_burst_sequencer;

    localparam int DEPTH = 8;
    localparam int GAP_W = 4;

    logic             clk = 1'b0;
    logic             rst, wr_en, enable, pg_stop;
    logic [3:0]       wr_data;
    logic [GAP_W-1:0] gap;
    logic             pg_start, full, empty, busy, wr_err;
    logic [3:0]       pg_limit;
    logic [7:0]       done_count;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: a plain queue for the FIFO and a few burst-phase flags.
    int q[$];
    bit m_launch, m_wait, m_wrerr;
    int m_gapleft, m_limit, m_done;

    burst_sequencer #(.DEPTH(DEPTH), .GAP_W(GAP_W)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .enable(enable), .gap(gap), .pg_stop(pg_stop),
        .pg_start(pg_start), .pg_limit(pg_limit), .full(full),
        .empty(empty), .busy(busy), .wr_err(wr_err), .done_count(done_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit m_busy, do_pop, do_push;
        int sz;
        if (rst) begin
            q.delete();
            m_launch = 0; m_wait = 0; m_wrerr = 0;
            m_gapleft = 0; m_limit = 0; m_done = 0;
            return;
        end
        sz      = q.size();
        m_busy  = m_launch || m_wait || (m_gapleft > 0);
        do_pop  = !m_busy && enable && (sz > 0);
        do_push = wr_en && (wr_data != 0) && ((sz < DEPTH) || do_pop);
        m_wrerr = wr_en && !do_push;
        if (m_launch) begin
            m_launch = 0;
            m_wait   = 1;
        end else if (m_wait) begin
            if (pg_stop) begin
                m_wait    = 0;
                m_done    = (m_done + 1) % 256;
                m_gapleft = int'(gap);
            end
        end else if (m_gapleft > 0) begin
            m_gapleft--;
        end else if (do_pop) begin
            m_limit  = q.pop_front();
            m_launch = 1;
        end
        if (do_push)
            q.push_back(int'(wr_data));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("pg_start",   int'(pg_start),   int'(m_launch));
        check("busy",       int'(busy),       int'(m_launch || m_wait || m_gapleft > 0));
        check("pg_limit",   int'(pg_limit),   m_limit);
        check("full",       int'(full),       int'(q.size() == DEPTH));
        check("empty",      int'(empty),      int'(q.size() == 0));
        check("wr_err",     int'(wr_err),     int'(m_wrerr));
        check("done_count", int'(done_count), m_done);
    endtask

    task automatic run(input int n, input int wr_pct, input int zero_pct,
                       input int en_pct, input int gap_max, input int stop_pct,
                       input int rst_pct, input int dmax);
        for (int i = 0; i < n; i++) begin
            rst     = ($urandom_range(0, 99) < rst_pct);
            wr_en   = ($urandom_range(0, 99) < wr_pct);
            wr_data = ($urandom_range(0, 99) < zero_pct) ? 4'd0
                      : 4'($urandom_range(1, dmax));
            enable  = ($urandom_range(0, 99) < en_pct);
            gap     = GAP_W'($urandom_range(0, gap_max));
            pg_stop = ($urandom_range(0, 99) < stop_pct);
            step();
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 4'd0;
        enable = 1'b0; gap = '0; pg_stop = 1'b0;
        step();
        step();
        rst = 1'b0;
        // fill with launches blocked: full flag and rejected writes
        run(300, 70, 10, 0, 3, 30, 0, 15);
        // drain back-to-back with no gap
        run(200, 0, 0, 100, 0, 30, 0, 15);
        run(400, 40, 10, 100, 0, 40, 0, 15);
        // everything random, including enable toggling and occasional reset
        run(1500, 40, 10, 70, 5, 30, 1, 15);
        // many unit-length bursts so done_count wraps
        run(2000, 60, 0, 100, 0, 50, 0, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
